// File: rtl/cmp_result_accumulator_pkg.sv
// cmp_pkg: FSM state encoding, default window length and one-hot flag check shared by the comparator result accumulator
package cmp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  localparam int WINDOW_DEFAULT = 8;
  function automatic logic onehot3(input logic l, input logic g, input logic e);
    return (l ^ g ^ e) & ~(l & g & e);
  endfunction
endpackage

// File: rtl/cmp_result_accumulator_eq_run_tracker.sv
// eq_run_tracker: longest run of consecutive equal samples; ports clk, rst_n, clr (drop runs), en (accepted beat), eq (one-hot equal sample), max_run (registered), max_next (value max_run takes on this beat)
module eq_run_tracker #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             eq,
  output logic [CNT_W-1:0] max_run,
  output logic [CNT_W-1:0] max_next
);
  logic [CNT_W-1:0] cur_run, cur_next;
  always_comb begin
    cur_next = eq ? cur_run + CNT_W'(1) : '0;
    max_next = cur_next > max_run ? cur_next : max_run;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_run <= '0;
      max_run <= '0;
    end else if (clr) begin
      cur_run <= '0;
      max_run <= '0;
    end else if (en) begin
      cur_run <= cur_next;
      max_run <= max_next;
    end
  end
endmodule

// File: rtl/cmp_result_accumulator.sv
// cmp_result_accumulator: tallies comparator flags over WINDOW samples and presents a registered summary; ports clk, rst_n, start, abort, in_valid/in_ready + less/greater/equal sample, out_valid/out_ready + lt/gt/eq counts, longest equal run, err
module cmp_result_accumulator
  import cmp_pkg::*;
#(
  parameter  int WINDOW = WINDOW_DEFAULT,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             less,
  input  logic             greater,
  input  logic             equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_eq_run,
  output logic             out_err
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] smp_cnt, lt_cnt, gt_cnt, eq_cnt, run_max, run_nxt;
  logic err, oh, acc, last, hs, clr;
  always_comb begin
    oh   = onehot3(less, greater, equal);
    acc  = in_valid && in_ready && !abort;
    last = acc && smp_cnt == CNT_W'(WINDOW - 1);
    hs   = out_valid && out_ready && !abort;
    clr  = abort || hs;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = abort            ? IDLE :
                state == IDLE    ? (start ? ACCUM : IDLE) :
                state == ACCUM   ? (last ? HOLD : ACCUM) :
                state == HOLD    ? (hs ? (start ? ACCUM : IDLE) : HOLD) :
                IDLE;
  end
  always_comb begin
    in_ready  = state == ACCUM;
    out_valid = state == HOLD;
  end
  eq_run_tracker #(.CNT_W(CNT_W)) u_run (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (acc),
    .eq      (oh && equal),
    .max_run (run_max),
    .max_next(run_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt <= '0;
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      err     <= 1'b0;
    end else if (clr) begin
      smp_cnt <= '0;
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      err     <= 1'b0;
    end else if (acc) begin
      smp_cnt <= smp_cnt + CNT_W'(1);
      lt_cnt  <= lt_cnt + CNT_W'(oh && less);
      gt_cnt  <= gt_cnt + CNT_W'(oh && greater);
      eq_cnt  <= eq_cnt + CNT_W'(oh && equal);
      err     <= err | !oh;
    end
  end
  // Summary includes the closing sample, so it is built from the pre-update counters plus that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lt_cnt <= '0;
      out_gt_cnt <= '0;
      out_eq_cnt <= '0;
      out_eq_run <= '0;
      out_err    <= 1'b0;
    end else if (last) begin
      out_lt_cnt <= lt_cnt + CNT_W'(oh && less);
      out_gt_cnt <= gt_cnt + CNT_W'(oh && greater);
      out_eq_cnt <= eq_cnt + CNT_W'(oh && equal);
      out_eq_run <= run_nxt;
      out_err    <= err | !oh;
    end
  end
endmodule

// File: tb/tb_cmp_result_accumulator.sv
// tb_cmp_result_accumulator: table-driven windows with a summary scoreboard plus backpressure, abort, gap and reset sequences
module tb_cmp_result_accumulator;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0;
  logic less = 0, greater = 0, equal = 0, out_ready = 0;
  logic in_ready, out_valid, out_err;
  logic [CW-1:0] out_lt_cnt, out_gt_cnt, out_eq_cnt, out_eq_run;
  typedef struct {
    logic [23:0]   f;
    logic [CW-1:0] lt, gt, eq, run;
    logic          err;
  } rec_t;
  rec_t q[$];
  rec_t tbl[6];
  int tests = 0, fails = 0;
  cmp_result_accumulator #(.WINDOW(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .less(less), .greater(greater), .equal(equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lt_cnt(out_lt_cnt), .out_gt_cnt(out_gt_cnt), .out_eq_cnt(out_eq_cnt),
    .out_eq_run(out_eq_run), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic feed(input logic [2:0] fl);
    int n = 0;
    {less, greater, equal} = fl;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic send(input logic [23:0] f, input bit gap, input rec_t e);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q.push_back(e);
      feed(f[23-3*i -: 3]);
      if (gap && i < 7) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("latency_out_valid", out_valid, 1);
  endtask
  task automatic handshake(input logic st);
    rec_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 0, 1);
      return;
    end
    e = q.pop_front();
    chk("lt_cnt", out_lt_cnt, e.lt);
    chk("gt_cnt", out_gt_cnt, e.gt);
    chk("eq_cnt", out_eq_cnt, e.eq);
    chk("eq_run", out_eq_run, e.run);
    chk("err", out_err, e.err);
    out_ready = 1;
    start = st;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("data_hold", {out_lt_cnt, out_gt_cnt, out_eq_cnt, out_eq_run, out_err}, {e.lt, e.gt, e.eq, e.run, e.err});
    chk("state_after_hs", in_ready, st);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{24'b100_100_010_001_001_001_010_001, 4'd2, 4'd2, 4'd4, 4'd3, 1'b0};
    tbl[1] = '{24'b001_001_000_001_001_110_001_001, 4'd0, 4'd0, 4'd6, 4'd2, 1'b1};
    tbl[2] = '{24'b001_001_001_001_001_001_001_001, 4'd0, 4'd0, 4'd8, 4'd8, 1'b0};
    tbl[3] = '{24'b010_010_010_010_010_010_010_010, 4'd0, 4'd8, 4'd0, 4'd0, 1'b0};
    tbl[4] = '{24'b001_100_001_001_111_001_001_001, 4'd1, 4'd0, 4'd6, 4'd3, 1'b1};
    tbl[5] = '{24'b001_001_001_001_001_001_001_100, 4'd1, 4'd0, 4'd7, 4'd7, 1'b0};
    #1;
    chk("reset_outputs", {in_ready, out_valid, out_lt_cnt, out_gt_cnt, out_eq_cnt, out_eq_run, out_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    in_valid = 1;
    equal = 1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ignore", {in_ready, out_valid}, 0);
    end
    in_valid = 0;
    chk("idle_no_counts", {out_lt_cnt, out_gt_cnt, out_eq_cnt, out_eq_run, out_err}, 0);
    start = 1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].f, 0, tbl[i]);
      handshake(i < 5);
    end
    start = 1;
    send(tbl[0].f, 0, tbl[0]);
    in_valid = 1;
    {less, greater, equal} = 3'b001;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, out_eq_cnt, out_eq_run, out_lt_cnt}, {1'b1, 1'b0, 4'd4, 4'd3, 4'd2});
    end
    in_valid = 0;
    handshake(1);
    send(tbl[2].f, 0, tbl[2]);
    handshake(0);
    start = 1;
    repeat (5) feed(3'b100);
    start = 0;
    in_valid = 1;
    abort = 1;
    @(posedge clk);
    @(negedge clk);
    abort = 0;
    in_valid = 0;
    chk("abort_idle", {in_ready, out_valid}, 0);
    chk("abort_data_keep", {out_eq_cnt, out_eq_run, out_lt_cnt}, {4'd8, 4'd8, 4'd0});
    start = 1;
    send(tbl[3].f, 0, tbl[3]);
    handshake(0);
    start = 1;
    send(tbl[2].f, 1, tbl[2]);
    handshake(0);
    start = 1;
    repeat (3) feed(3'b001);
    #2 rst_n = 0;
    #1;
    chk("reset_mid_window", {in_ready, out_valid, out_lt_cnt, out_gt_cnt, out_eq_cnt, out_eq_run, out_err}, 0);
    @(negedge clk);
    rst_n = 1;
    start = 0;
    repeat (2) @(negedge clk);
    chk("reset_stays_idle", {in_ready, out_valid}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmp_result_accumulator.md
Name: cmp_result_accumulator

Overview:
- Downstream stage of the 4-bit magnitude comparator; consumes its less/greater/equal flags, one sample per accepted beat.
- Tallies results over a window of WINDOW samples and tracks the longest run of consecutive "equal" samples.
- Flags samples whose flags are not one-hot.
- Presents a registered window summary on a valid/ready output handshake; feeds lab status display/logging.

Parameters:
- WINDOW, 8, samples per window; legal range 2..255.
- CNT_W, $clog2(WINDOW+1), width of all counters; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; IDLE->ACCUM request, also selects continuous operation after a handshake
- abort  input  1  synchronous; discards current window
- in_valid  input  1  sample present
- in_ready  output  1  block accepts a sample this cycle
- less  input  1  comparator flag a<b
- greater  input  1  comparator flag a>b
- equal  input  1  comparator flag a==b
- out_valid  output  1  summary available
- out_ready  input  1  consumer takes summary
- out_lt_cnt  output  CNT_W  count of less samples in window
- out_gt_cnt  output  CNT_W  count of greater samples in window
- out_eq_cnt  output  CNT_W  count of equal samples in window
- out_eq_run  output  CNT_W  longest consecutive-equal run in window
- out_err  output  1  at least one non-one-hot sample in window

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; all internal counters 0.
  - All outputs 0, including in_ready and out_valid.
- Accept: a sample is taken when in_valid && in_ready.
- FSM states IDLE, ACCUM, HOLD:
  - IDLE: in_ready=0, out_valid=0. start=1 -> ACCUM next cycle.
  - ACCUM: in_ready=1, out_valid=0. Each accepted sample:
    - Increments the sample counter.
    - Exactly one flag high: increments the matching lt/gt/eq counter.
    - Flags not one-hot (none or several high): sets sticky err; no lt/gt/eq counter changes; still counts toward WINDOW.
  - ACCUM -> HOLD: on acceptance of the WINDOW-th sample.
    - That sample's effect is included in the summary.
    - out_* are loaded on the same edge; out_valid=1 from the next cycle (1-cycle latency).
  - HOLD: in_ready=0, out_valid=1; out_* stable until handshake.
    - out_valid && out_ready: working counters, run trackers and err clear.
    - Then -> ACCUM if start=1 that cycle, else -> IDLE.
- Equal-run tracking:
  - cur_run increments on a one-hot equal sample, else resets to 0.
  - max_run = max(max_run, updated cur_run), evaluated on the same accepted beat.
  - A run ending on the final sample is counted.
  - Runs never carry across windows.
- Counter widths: CNT_W bits cannot overflow, since every count is <= WINDOW. out_lt_cnt + out_gt_cnt + out_eq_cnt + (error samples) == WINDOW.
- Output data hold: out_* keep the last summary after the handshake (only out_valid drops). They are overwritten only at the next window completion.
- abort:
  - In any state, abort=1 -> IDLE next cycle; working counters/err cleared; out_valid=0.
  - out_* data retain the previous values.
  - Has priority over sample acceptance and handshake in the same cycle.
- Simultaneous events: in HOLD, in_valid is ignored because in_ready=0. No sample is lost across the HOLD->ACCUM transition, since the upstream stalls.
- in_valid without start in IDLE: ignored, no state change.
- start deasserted mid-ACCUM: window continues to completion; start is only sampled in IDLE and at the HOLD handshake.
- Reset mid-window: everything is lost immediately; no partial summary.

Decomposition:
- Shared package `cmp_pkg`:
  - State enum: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Localparam for the default WINDOW.
  - Function onehot3(l,g,e).
- One natural sub-module, `eq_run_tracker`: cur_run/max_run registers with clear and an accepted-beat enable, outputting max_run.
- Counters and the FSM stay in the top.

Test Plan:
- Reset/idle: rst_n low mid-operation -> all outputs 0 immediately. After release with start=0 and in_valid=1 for 10 cycles -> in_ready=0, out_valid=0, no counts.
- Basic window: WINDOW=8, start=1, samples L,L,G,E,E,E,G,E back-to-back -> out_valid on the cycle after sample 8; lt=2, gt=2, eq=4, eq_run=3, err=0.
- Error samples: 8 samples including {l,g,e}=000 and 110, plus 6 equal with the errors at positions 3 and 6 -> eq=6, lt=0, gt=0, err=1, eq_run=2.
- Output backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid and data stable, in_ready=0. With start=1 at the handshake -> ACCUM next cycle. The next window of 8 equal samples -> eq=8, eq_run=8, with no carry from the previous window.
- Abort: abort asserted after 5 accepted samples, with in_valid=1 in the same cycle -> IDLE, that sample not counted, out_valid stays 0. A restarted window of 8 greater samples -> gt=8.
- Gapped input: in_valid toggling 1/0 across 16 cycles with 8 equal samples -> eq=8, eq_run=8 (idle cycles do not break the run).
